// File: rtl/alu_cmd_issuer_if.sv
// Request/response channel between the command issuer and the board ALU.
// The issuer is the master; the ALU is the slave.
interface alu_cmd_issuer_if #(
    parameter int DW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_func;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          rsp_valid;
    logic [DW-1:0] rsp_result;
    logic          rsp_cout;
    logic          rsp_overflow;

    modport master (
        output req_valid, req_func, req_a, req_b,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_overflow
    );

    modport slave (
        input  req_valid, req_func, req_a, req_b,
        output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_overflow
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Button-driven ALU command issuer with debounce, timeout and LED status.
// Optional AUTO_SWEEP_EN: sw[15] issues ops back to back from a sweep counter.
module alu_cmd_issuer #(
    parameter int DW              = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT         = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           sw,
    input  logic                  btn,
    alu_cmd_issuer_if.master      bus,
    output logic [15:0]           ledr
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] db_cnt;
    logic          db_level;
    logic          db_prev;
    logic          go;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    res;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic          err;
    logic [6:0]    op_cnt;

    logic          start;
    logic [2:0]    nxt_func;
    logic [DW-1:0] nxt_a;
    logic [DW-1:0] nxt_b;
    logic          done;
    logic          unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            go       <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            db_prev <= db_level;
            go      <= db_level & ~db_prev;
            // any return to the current level restarts the stability window
            if (sync[1] != db_level) begin
                if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= sync[1];
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign done = (state == WAIT) &&
                  (bus.rsp_valid || tmo_cnt == TW'(TIMEOUT - 1));

`ifdef AUTO_SWEEP_EN
    logic [2*DW+2:0] sweep;
    logic            auto_op;

    always_comb begin
        start    = sw[15] ? 1'b1 : go;
        nxt_func = sw[15] ? sweep[2*DW+2:2*DW] : sw[10:8];
        nxt_b    = sw[15] ? sweep[2*DW-1:DW] : DW'(sw[7:4]);
        nxt_a    = sw[15] ? sweep[DW-1:0] : DW'(sw[3:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep   <= '0;
            auto_op <= 1'b0;
        end else begin
            if (state == IDLE && start)
                auto_op <= sw[15];
            if (done && auto_op)
                sweep <= sweep + 1'b1;
        end
    end

    assign unused = ^{sw[14:11]};
`else
    always_comb begin
        start    = go;
        nxt_func = sw[10:8];
        nxt_b    = DW'(sw[7:4]);
        nxt_a    = DW'(sw[3:0]);
    end

    assign unused = ^{sw[15:11], done};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.req_valid <= 1'b0;
            bus.req_func  <= '0;
            bus.req_a     <= '0;
            bus.req_b     <= '0;
            tmo_cnt       <= '0;
            res           <= '0;
            cout          <= 1'b0;
            ovf           <= 1'b0;
            zero          <= 1'b0;
            err           <= 1'b0;
            op_cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bus.req_func  <= nxt_func;
                        bus.req_a     <= nxt_a;
                        bus.req_b     <= nxt_b;
                        bus.req_valid <= 1'b1;
                        err           <= 1'b0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.req_ready) begin
                        bus.req_valid <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // a response on the final timeout cycle still counts
                    if (bus.rsp_valid) begin
                        res    <= 4'(bus.rsp_result);
                        cout   <= bus.rsp_cout;
                        ovf    <= bus.rsp_overflow;
                        zero   <= ~|bus.rsp_result;
                        op_cnt <= op_cnt + 1'b1;
                        state  <= IDLE;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ledr = {op_cnt, err, state != IDLE, zero, ovf, cout, res};
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with hand-computed LED and payload values.
// Bus slave side is driven straight from the stimulus sequence.
module tb_alu_cmd_issuer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw  = '0;
    logic        btn = 1'b0;
    logic [15:0] ledr;
    int          n_cmp = 0;
    int          n_bad = 0;

    alu_cmd_issuer_if #(.DW(4)) bus ();

    alu_cmd_issuer dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .btn  (btn),
        .bus  (bus),
        .ledr (ledr)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(string tag);
        int lat;
        lat = 0;
        btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (bus.req_valid) begin
                lat = i;
                break;
            end
        end
        chk(tag, lat, 20);
    endtask

    task automatic release_btn();
        btn = 1'b0;
        step(22);
    endtask

    task automatic xfer();
        bus.req_ready = 1'b1;
        step(1);
        bus.req_ready = 1'b0;
    endtask

    task automatic respond(logic [3:0] r, logic c, logic o);
        step(1);
        bus.rsp_result   = r;
        bus.rsp_cout     = c;
        bus.rsp_overflow = o;
        bus.rsp_valid    = 1'b1;
        step(1);
        bus.rsp_valid    = 1'b0;
    endtask

    task automatic run_op(logic [15:0] s, logic [3:0] r);
        sw = s;
        press("lat_loop");
        xfer();
        respond(r, 1'b0, 1'b0);
        release_btn();
    endtask

    initial begin
        logic seen;
        int   n;

        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_result   = '0;
        bus.rsp_cout     = 1'b0;
        bus.rsp_overflow = 1'b0;

        step(3);
        chk("rst_ledr", ledr, 16'h0000);
        chk("rst_valid", bus.req_valid, 1'b0);
        chk("rst_payload", {bus.req_func, bus.req_a, bus.req_b}, 11'h0);
        rst = 1'b0;
        step(2);

        sw = 16'h0053;
        press("lat_first");
        chk("t2_payload", {bus.req_func, bus.req_a, bus.req_b}, {3'd0, 4'd3, 4'd5});
        chk("t2_busy", ledr[7], 1'b1);
        xfer();
        chk("t2_valid_drop", bus.req_valid, 1'b0);
        respond(4'd8, 1'b0, 1'b0);
        chk("t2_ledr", ledr, 16'h0208);
        release_btn();

        btn = 1'b1;
        step(5);
        btn  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            seen |= bus.req_valid;
        end
        chk("t3_glitch", seen, 1'b0);

        sw = 16'h0127;
        press("lat_t4");
        for (int i = 0; i < 10; i++) begin
            sw = sw ^ 16'h7fff;
            step(1);
            chk("t4_hold", {bus.req_valid, bus.req_func, bus.req_a, bus.req_b},
                {1'b1, 3'd1, 4'd7, 4'd2});
        end
        xfer();
        chk("t4_xfer", bus.req_valid, 1'b0);
        respond(4'd0, 1'b1, 1'b0);
        chk("t4_ledr", ledr, 16'h0450);
        release_btn();

        sw = 16'h0031;
        press("lat_t5");
        xfer();
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            step(1);
            if (ledr[8]) begin
                n = i;
                break;
            end
        end
        chk("t5_tmo_cycles", n, 255);
        chk("t5_tmo_ledr", ledr, 16'h0550);
        release_btn();
        run_op(16'h0011, 4'd2);
        chk("t5_err_clear", ledr, 16'h0602);

        sw = 16'h0022;
        press("lat_race");
        xfer();
        step(254);
        chk("race_busy", ledr[8:7], 2'b01);
        bus.rsp_result   = 4'hf;
        bus.rsp_cout     = 1'b0;
        bus.rsp_overflow = 1'b1;
        bus.rsp_valid    = 1'b1;
        step(1);
        bus.rsp_valid = 1'b0;
        chk("race_ledr", ledr, 16'h082f);
        bus.rsp_result = 4'h1;
        bus.rsp_valid  = 1'b1;
        step(1);
        bus.rsp_valid = 1'b0;
        step(1);
        chk("stray_rsp", ledr, 16'h082f);
        release_btn();

        sw = 16'h0044;
        press("lat_rreq");
        rst = 1'b1;
        step(1);
        chk("rst_req_valid", bus.req_valid, 1'b0);
        chk("rst_req_ledr", ledr, 16'h0000);
        rst = 1'b0;
        release_btn();
        press("lat_rwait");
        xfer();
        step(1);
        rst = 1'b1;
        step(1);
        chk("rst_wait_ledr", ledr, 16'h0000);
        rst = 1'b0;
        release_btn();

        for (int i = 0; i < 128; i++) begin
            run_op(16'h0021, 4'd3);
            if (i == 126)
                chk("cnt_127", ledr[15:9], 7'd127);
        end
        chk("cnt_wrap", ledr, 16'h0003);

`ifdef AUTO_SWEEP_EN
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sw  = 16'h8000;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                step(1);
                if (bus.req_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("sweep_issue", seen, 1'b1);
            chk("sweep_payload", {bus.req_func, bus.req_b, bus.req_a}, k);
            xfer();
            bus.rsp_valid = 1'b1;
            step(1);
            bus.rsp_valid = 1'b0;
            if (k == 3)
                sw = 16'h0000;
        end
        step(3);
        chk("sweep_stop", bus.req_valid, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
